// File: rtl/simon_sound_sched.sv
// Simon game sound scheduler: arbitrates the live button tone against the win/lose/high-score
// jingles and drives one speaker pin with a square wave from a per-note half-period divider.
module simon_sound_sched #(
  parameter int DIV_W    = 16,
  parameter int HP_0     = 50000,
  parameter int HP_1     = 40000,
  parameter int HP_2     = 33333,
  parameter int HP_3     = 25000,
  parameter int NOTE_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       tone_req,
  input  logic [1:0] tone_idx,
  input  logic       win,
  input  logic       lose,
  input  logic       hs,
  input  logic       mute,
  output logic       spk,
  output logic       busy,
  output logic [2:0] src
);

  localparam int TCNT_W = (NOTE_LEN > 1) ? $clog2(NOTE_LEN) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(NOTE_LEN - 1);

  // Jingle codes double as priority (higher value wins); pending bit = code - 1.
  localparam logic [1:0] J_HS   = 2'd1;
  localparam logic [1:0] J_WIN  = 2'd2;
  localparam logic [1:0] J_LOSE = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_TONE, ST_JINGLE, ST_GAP} state_t;

  function automatic logic [DIV_W-1:0] half_period_last(input logic [1:0] n);
    case (n)
      2'd0:    return DIV_W'(HP_0 - 1);
      2'd1:    return DIV_W'(HP_1 - 1);
      2'd2:    return DIV_W'(HP_2 - 1);
      default: return DIV_W'(HP_3 - 1);
    endcase
  endfunction

  function automatic logic [1:0] jingle_note(input logic [1:0] j, input logic [1:0] k);
    case (j)
      J_WIN:   return k;
      J_LOSE:  return 2'd3 - k;
      default: return {k[0], k[0]};
    endcase
  endfunction

  function automatic logic [2:0] accept_mask(input state_t s, input logic [1:0] j);
    if (s == ST_JINGLE || s == ST_GAP) begin
      case (j)
        J_HS:    return 3'b110;
        J_WIN:   return 3'b100;
        default: return 3'b000;
      endcase
    end
    return 3'b111;
  endfunction

  function automatic logic [2:0] src_code(input state_t s, input logic [1:0] j);
    case (s)
      ST_IDLE:   return 3'b000;
      ST_TONE:   return 3'b001;
      ST_GAP:    return 3'b101;
      default:   return (j == J_HS) ? 3'b010 : (j == J_WIN) ? 3'b011 : 3'b100;
    endcase
  endfunction

  state_t              state, state_n;
  logic [1:0]          cur_j, j_n;
  logic [1:0]          note_k, k_n;
  logic [1:0]          note, note_n;
  logic [TCNT_W-1:0]   tick_cnt, tcnt_n;
  logic [DIV_W-1:0]    div;
  logic                spk_int;
  logic                win_p1, lose_p1, hs_p1, armed;
  logic [2:0]          pend, pend_n, edges, clr;
  logic [1:0]          start_j;
  logic                restart;

  // armed keeps a level already high when reset releases from looking like a new edge.
  assign edges   = armed ? {lose & ~lose_p1, win & ~win_p1, hs & ~hs_p1} : 3'b000;
  assign start_j = pend[2] ? J_LOSE : pend[1] ? J_WIN : pend[0] ? J_HS : 2'd0;

  always_comb begin
    state_n = state;
    j_n     = cur_j;
    k_n     = note_k;
    note_n  = note;
    tcnt_n  = tick_cnt;
    clr     = 3'b000;
    restart = 1'b0;
    if (start_j != 2'd0) begin
      state_n = ST_JINGLE;
      j_n     = start_j;
      k_n     = 2'd0;
      tcnt_n  = '0;
      note_n  = jingle_note(start_j, 2'd0);
      clr     = (start_j == J_LOSE) ? 3'b111 : (start_j == J_WIN) ? 3'b011 : 3'b001;
      restart = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tone_req) begin
            state_n = ST_TONE;
            note_n  = tone_idx;
          end
        end
        ST_TONE: begin
          if (!tone_req) begin
            state_n = ST_IDLE;
          end else begin
            note_n  = tone_idx;
            restart = (tone_idx != note);
          end
        end
        ST_JINGLE: begin
          if (tick) begin
            if (tick_cnt == TCNT_LAST) begin
              tcnt_n = '0;
              if (note_k == 2'd3) begin
                state_n = ST_GAP;
              end else begin
                k_n     = note_k + 2'd1;
                note_n  = jingle_note(cur_j, note_k + 2'd1);
                restart = 1'b1;
              end
            end else begin
              tcnt_n = tick_cnt + 1'b1;
            end
          end
        end
        default: begin
          if (tick) begin
            if (tick_cnt == TCNT_LAST) begin
              tcnt_n  = '0;
              state_n = ST_IDLE;
            end else begin
              tcnt_n = tick_cnt + 1'b1;
            end
          end
        end
      endcase
    end
    if (state_n != state) restart = 1'b1;
    // Equal/lower-priority requests relative to what will be playing are dropped outright.
    pend_n = ((pend & ~clr) | edges) & accept_mask(state_n, j_n);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cur_j    <= 2'd0;
      note_k   <= 2'd0;
      note     <= 2'd0;
      tick_cnt <= '0;
      pend     <= 3'b000;
      win_p1   <= 1'b0;
      lose_p1  <= 1'b0;
      hs_p1    <= 1'b0;
      armed    <= 1'b0;
      div      <= '0;
      spk_int  <= 1'b0;
      src      <= 3'b000;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      cur_j    <= j_n;
      note_k   <= k_n;
      note     <= note_n;
      tick_cnt <= tcnt_n;
      pend     <= pend_n;
      win_p1   <= win;
      lose_p1  <= lose;
      hs_p1    <= hs;
      armed    <= 1'b1;
      src      <= src_code(state_n, j_n);
      busy     <= (state_n == ST_JINGLE) || (state_n == ST_GAP);
      if (restart || !(state_n == ST_TONE || state_n == ST_JINGLE)) begin
        div     <= '0;
        spk_int <= 1'b0;
      end else if (div == half_period_last(note)) begin
        div     <= '0;
        spk_int <= ~spk_int;
      end else begin
        div     <= div + 1'b1;
      end
    end
  end

  assign spk = spk_int & ~mute;

endmodule

// File: tb/tb_simon_sound_sched.sv
// Directed bench for simon_sound_sched with short notes (half-periods 4..7) and a 100-cycle tick.
module tb_simon_sound_sched;

  localparam int TPER = 100;

  logic       clk = 1'b0;
  logic       rst, tick, tone_req, win, lose, hs, mute;
  logic [1:0] tone_idx;
  logic       spk, busy;
  logic [2:0] src;

  int checks = 0;
  int errors = 0;
  int off    = 0;
  int tcnt   = 0;
  bit tick_run = 1'b0;

  always #5 clk = ~clk;

  simon_sound_sched #(
    .DIV_W(16), .HP_0(4), .HP_1(5), .HP_2(6), .HP_3(7), .NOTE_LEN(2)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .tone_req(tone_req), .tone_idx(tone_idx),
    .win(win), .lose(lose), .hs(hs), .mute(mute), .spk(spk), .busy(busy), .src(src)
  );

  task automatic step();
    @(posedge clk);
    #1;
    off++;
    tick = 1'b0;
    if (tick_run) begin
      tcnt++;
      if (tcnt == TPER) begin
        tick = 1'b1;
        tcnt = 0;
      end
    end
  endtask

  task automatic advance_to(input int t);
    while (off < t) step();
  endtask

  task automatic restart_timebase();
    off = 0;
    tcnt = 0;
    tick = 1'b0;
    tick_run = 1'b1;
  endtask

  // Cycles between two consecutive spk toggles; 0 when spk holds steady for 20 cycles.
  task automatic measure_hp(output int hp);
    logic s0;
    int n;
    hp = 0;
    s0 = spk;
    n = 0;
    while (spk === s0 && n < 20) begin step(); n++; end
    if (spk === s0) return;
    s0 = spk;
    n = 0;
    while (spk === s0 && n < 20) begin step(); n++; end
    if (spk !== s0) hp = n;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 1'b0; tone_req = 1'b0; tone_idx = 2'd0;
    win = 1'b0; lose = 1'b0; hs = 1'b0; mute = 1'b0;
    step(); step();
    checks++; if (spk !== 1'b0) begin errors++; $display("FAIL reset_spk got %0b exp 0", spk); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (src !== 3'b000) begin errors++; $display("FAIL reset_src got %0d exp 0", src); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_tone();
    int hp;
    tone_req = 1'b1; tone_idx = 2'd2;
    step();
    checks++; if (src !== 3'b001) begin errors++; $display("FAIL tone_src got %0d exp 1", src); end
    repeat (5) step();
    checks++; if (spk !== 1'b0) begin errors++; $display("FAIL tone_pre_rise got %0b exp 0", spk); end
    step();
    checks++; if (spk !== 1'b1) begin errors++; $display("FAIL tone_first_rise got %0b exp 1", spk); end
    repeat (6) step();
    checks++; if (spk !== 1'b0) begin errors++; $display("FAIL tone_fall got %0b exp 0", spk); end
    measure_hp(hp);
    checks++; if (hp != 6) begin errors++; $display("FAIL tone_hp_idx2 got %0d exp 6", hp); end
    tone_idx = 2'd0;
    measure_hp(hp);
    checks++; if (hp != 4) begin errors++; $display("FAIL tone_hp_idx0 got %0d exp 4", hp); end
    tone_req = 1'b0;
    step();
    checks++; if (src !== 3'b000) begin errors++; $display("FAIL tone_off_src got %0d exp 0", src); end
    checks++; if (spk !== 1'b0) begin errors++; $display("FAIL tone_off_spk got %0b exp 0", spk); end
  endtask

  task automatic test_win();
    int hp;
    int exp_hp[4] = '{4, 5, 6, 7};
    win = 1'b1;
    step();
    checks++; if (src !== 3'b000) begin errors++; $display("FAIL win_pending_src got %0d exp 0", src); end
    step();
    checks++; if (src !== 3'b011) begin errors++; $display("FAIL win_src got %0d exp 3", src); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL win_busy got %0b exp 1", busy); end
    restart_timebase();
    repeat (3) step();
    checks++; if (spk !== 1'b0) begin errors++; $display("FAIL win_pre_rise got %0b exp 0", spk); end
    step();
    checks++; if (spk !== 1'b1) begin errors++; $display("FAIL win_first_rise got %0b exp 1", spk); end
    for (int k = 0; k < 4; k++) begin
      advance_to(200 * k + 50);
      measure_hp(hp);
      checks++; if (hp != exp_hp[k]) begin errors++; $display("FAIL win_note%0d_hp got %0d exp %0d", k, hp, exp_hp[k]); end
      checks++; if (src !== 3'b011) begin errors++; $display("FAIL win_note%0d_src got %0d exp 3", k, src); end
    end
    advance_to(850);
    checks++; if (src !== 3'b101) begin errors++; $display("FAIL win_gap_src got %0d exp 5", src); end
    checks++; if (spk !== 1'b0) begin errors++; $display("FAIL win_gap_spk got %0b exp 0", spk); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL win_gap_busy got %0b exp 1", busy); end
    advance_to(1050);
    checks++; if (src !== 3'b000) begin errors++; $display("FAIL win_done_src got %0d exp 0", src); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL win_done_busy got %0b exp 0", busy); end
    win = 1'b0; tick_run = 1'b0;
    step();
  endtask

  task automatic test_simultaneous();
    int hp;
    int exp_hp[4] = '{7, 6, 5, 4};
    win = 1'b1; lose = 1'b1;
    step(); step();
    checks++; if (src !== 3'b100) begin errors++; $display("FAIL simul_src got %0d exp 4", src); end
    restart_timebase();
    for (int k = 0; k < 4; k++) begin
      advance_to(200 * k + 50);
      measure_hp(hp);
      checks++; if (hp != exp_hp[k]) begin errors++; $display("FAIL lose_note%0d_hp got %0d exp %0d", k, hp, exp_hp[k]); end
    end
    advance_to(1050);
    checks++; if (src !== 3'b000) begin errors++; $display("FAIL simul_done_src got %0d exp 0", src); end
    advance_to(1100);
    checks++; if (src !== 3'b000) begin errors++; $display("FAIL simul_no_win got %0d exp 0", src); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL simul_no_win_busy got %0b exp 0", busy); end
    win = 1'b0; lose = 1'b0; tick_run = 1'b0;
    step();
  endtask

  task automatic test_preempt();
    int hp;
    hs = 1'b1;
    step(); step();
    checks++; if (src !== 3'b010) begin errors++; $display("FAIL hs_src got %0d exp 2", src); end
    restart_timebase();
    advance_to(250);
    measure_hp(hp);
    checks++; if (hp != 7) begin errors++; $display("FAIL hs_note1_hp got %0d exp 7", hp); end
    advance_to(450);
    measure_hp(hp);
    checks++; if (hp != 4) begin errors++; $display("FAIL hs_note2_hp got %0d exp 4", hp); end
    lose = 1'b1;
    step(); step();
    checks++; if (src !== 3'b100) begin errors++; $display("FAIL lose_preempt_src got %0d exp 4", src); end
    restart_timebase();
    measure_hp(hp);
    checks++; if (hp != 7) begin errors++; $display("FAIL lose_restart_hp got %0d exp 7", hp); end
    advance_to(250);
    win = 1'b1;
    step(); step();
    checks++; if (src !== 3'b100) begin errors++; $display("FAIL win_ignored_src got %0d exp 4", src); end
    measure_hp(hp);
    checks++; if (hp != 6) begin errors++; $display("FAIL lose_note1_hp got %0d exp 6", hp); end
    advance_to(1050);
    checks++; if (src !== 3'b000) begin errors++; $display("FAIL win_discarded_src got %0d exp 0", src); end
    win = 1'b0; lose = 1'b0; hs = 1'b0; tick_run = 1'b0;
    step();
  endtask

  task automatic test_tone_preempt_mute();
    int hp;
    int highs;
    tone_req = 1'b1; tone_idx = 2'd1;
    step();
    checks++; if (src !== 3'b001) begin errors++; $display("FAIL tone2_src got %0d exp 1", src); end
    hs = 1'b1;
    step();
    checks++; if (src !== 3'b001) begin errors++; $display("FAIL tone2_pending_src got %0d exp 1", src); end
    step();
    checks++; if (src !== 3'b010) begin errors++; $display("FAIL hs_preempt_src got %0d exp 2", src); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hs_preempt_busy got %0b exp 1", busy); end
    restart_timebase();
    advance_to(250);
    mute = 1'b1;
    highs = 0;
    repeat (20) begin
      step();
      if (spk !== 1'b0) highs++;
    end
    checks++; if (highs != 0) begin errors++; $display("FAIL mute_spk got %0d high cycles exp 0", highs); end
    checks++; if (src !== 3'b010) begin errors++; $display("FAIL mute_src got %0d exp 2", src); end
    mute = 1'b0;
    measure_hp(hp);
    checks++; if (hp != 7) begin errors++; $display("FAIL unmute_hp got %0d exp 7", hp); end
    advance_to(1050);
    checks++; if (src !== 3'b001) begin errors++; $display("FAIL tone_resume_src got %0d exp 1", src); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tone_resume_busy got %0b exp 0", busy); end
    tone_req = 1'b0; hs = 1'b0; tick_run = 1'b0;
    step();
    checks++; if (src !== 3'b000) begin errors++; $display("FAIL tone2_off_src got %0d exp 0", src); end
  endtask

  task automatic test_reset_mid();
    int n;
    win = 1'b1;
    step(); step();
    checks++; if (src !== 3'b011) begin errors++; $display("FAIL mid_win_src got %0d exp 3", src); end
    restart_timebase();
    n = 0;
    while (spk !== 1'b1 && n < 20) begin step(); n++; end
    checks++; if (spk !== 1'b1) begin errors++; $display("FAIL mid_pre_reset_spk got %0b exp 1", spk); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (spk !== 1'b0) begin errors++; $display("FAIL async_reset_spk got %0b exp 0", spk); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy got %0b exp 0", busy); end
    checks++; if (src !== 3'b000) begin errors++; $display("FAIL async_reset_src got %0d exp 0", src); end
    step(); step();
    rst = 1'b0;
    repeat (6) step();
    checks++; if (src !== 3'b000) begin errors++; $display("FAIL no_edge_after_reset_src got %0d exp 0", src); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL no_edge_after_reset_busy got %0b exp 0", busy); end
    win = 1'b0; tick_run = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_tone();
    test_win();
    test_simultaneous();
    test_preempt();
    test_tone_preempt_mute();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
